// File: rtl/axi4l_pkg.sv
// Shared AXI4-Lite encodings used by the command master and its peers.
package axi4l_pkg;

    typedef logic [1:0] axi_resp_t;

    localparam axi_resp_t AXI_RESP_OKAY   = 2'b00;
    localparam axi_resp_t AXI_RESP_EXOKAY = 2'b01;
    localparam axi_resp_t AXI_RESP_SLVERR = 2'b10;
    localparam axi_resp_t AXI_RESP_DECERR = 2'b11;

    // Unprivileged, secure, data access on every request.
    localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

endpackage

// File: rtl/axi4l_cmd_master_if.sv
// AXI4-Lite bus bundle; master modport drives requests, slave modport answers.
interface axi4l_cmd_master_if #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 32
);
    import axi4l_pkg::*;

    localparam int STRB_WIDTH = AXI_DATA_WIDTH / 8;

    logic [AXI_ADDR_WIDTH-1:0] awaddr;
    logic [2:0]                awprot;
    logic                      awvalid;
    logic                      awready;

    logic [AXI_DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0]     wstrb;
    logic                      wvalid;
    logic                      wready;

    axi_resp_t                 bresp;
    logic                      bvalid;
    logic                      bready;

    logic [AXI_ADDR_WIDTH-1:0] araddr;
    logic [2:0]                arprot;
    logic                      arvalid;
    logic                      arready;

    logic [AXI_DATA_WIDTH-1:0] rdata;
    axi_resp_t                 rresp;
    logic                      rvalid;
    logic                      rready;

    modport master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input bresp, bvalid, output bready,
        output araddr, arprot, arvalid, input arready,
        input rdata, rresp, rvalid, output rready
    );

    modport slave (
        input awaddr, awprot, awvalid, output awready,
        input wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );

endinterface

// File: rtl/axi4l_cmd_master.sv
// Single-outstanding AXI4-Lite initiator: one command in, one bus transaction,
// one response out. Commands outside the address window finish locally with DECERR.
module axi4l_cmd_master
    import axi4l_pkg::*;
#(
    parameter int                        AXI_ADDR_WIDTH = 32,
    parameter int                        AXI_DATA_WIDTH = 32,
    parameter logic [AXI_ADDR_WIDTH-1:0] AXI_BASE_ADDR  = 32'h0000_0000,
    parameter logic [AXI_ADDR_WIDTH-1:0] AXI_BASE_MASK  = 32'hFFFF_F000
) (
    input  logic                        axi_aclk,
    input  logic                        axi_aresetn,

    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic                        cmd_write,
    input  logic [AXI_ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [AXI_DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0] cmd_wstrb,

    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [AXI_DATA_WIDTH-1:0]   rsp_rdata,
    output axi_resp_t                   rsp_resp,

    output logic                        busy,

    axi4l_cmd_master_if.master          m_axi
);

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_RESP,
        RSP
    } state_t;

    state_t state;
    logic   aw_done;
    logic   w_done;
    logic   in_window;
    logic   aw_hs;
    logic   w_hs;

    assign in_window = (cmd_addr & AXI_BASE_MASK) == (AXI_BASE_ADDR & AXI_BASE_MASK);
    assign aw_hs     = m_axi.awvalid && m_axi.awready;
    assign w_hs      = m_axi.wvalid && m_axi.wready;

    assign m_axi.awprot = AXI_PROT_DEFAULT;
    assign m_axi.arprot = AXI_PROT_DEFAULT;

    // Command/transaction sequencer; every bus and response output is a register here.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            state         <= IDLE;
            cmd_ready     <= 1'b0;
            busy          <= 1'b0;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_rdata     <= '0;
            rsp_resp      <= AXI_RESP_OKAY;
            m_axi.awaddr  <= '0;
            m_axi.awvalid <= 1'b0;
            m_axi.wdata   <= '0;
            m_axi.wstrb   <= '0;
            m_axi.wvalid  <= 1'b0;
            m_axi.bready  <= 1'b0;
            m_axi.araddr  <= '0;
            m_axi.arvalid <= 1'b0;
            m_axi.rready  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // cmd_ready comes up one edge after reset release and stays up while idle.
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        if (!in_window) begin
                            state     <= RSP;
                            rsp_valid <= 1'b1;
                            rsp_resp  <= AXI_RESP_DECERR;
                            rsp_rdata <= '0;
                        end else if (cmd_write) begin
                            state         <= WR_REQ;
                            m_axi.awaddr  <= cmd_addr;
                            m_axi.wdata   <= cmd_wdata;
                            m_axi.wstrb   <= cmd_wstrb;
                            m_axi.awvalid <= 1'b1;
                            m_axi.wvalid  <= 1'b1;
                            aw_done       <= 1'b0;
                            w_done        <= 1'b0;
                        end else begin
                            state         <= RD_REQ;
                            m_axi.araddr  <= cmd_addr;
                            m_axi.arvalid <= 1'b1;
                        end
                    end
                end

                WR_REQ: begin
                    // AW and W retire independently; B is only opened once both have gone.
                    if (aw_hs) begin
                        m_axi.awvalid <= 1'b0;
                        aw_done       <= 1'b1;
                    end
                    if (w_hs) begin
                        m_axi.wvalid <= 1'b0;
                        w_done       <= 1'b1;
                    end
                    if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                        state        <= WR_RESP;
                        m_axi.bready <= 1'b1;
                    end
                end

                WR_RESP: begin
                    if (m_axi.bvalid) begin
                        state        <= RSP;
                        m_axi.bready <= 1'b0;
                        rsp_valid    <= 1'b1;
                        rsp_resp     <= m_axi.bresp;
                        rsp_rdata    <= '0;
                    end
                end

                RD_REQ: begin
                    if (m_axi.arready) begin
                        state         <= RD_RESP;
                        m_axi.arvalid <= 1'b0;
                        m_axi.rready  <= 1'b1;
                    end
                end

                RD_RESP: begin
                    if (m_axi.rvalid) begin
                        state        <= RSP;
                        m_axi.rready <= 1'b0;
                        rsp_valid    <= 1'b1;
                        rsp_resp     <= m_axi.rresp;
                        rsp_rdata    <= m_axi.rdata;
                    end
                end

                RSP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        cmd_ready <= 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi4l_cmd_master.sv
// Directed + randomized bench for axi4l_cmd_master with a behavioural AXI slave
// and a transaction-level response model.
module tb_axi4l_cmd_master;
    import axi4l_pkg::*;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int SW  = DW / 8;
    localparam int TMO = 100;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [SW-1:0] cmd_wstrb;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    axi_resp_t     rsp_resp;
    logic          busy;

    axi4l_cmd_master_if #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW)) m_axi ();

    axi4l_cmd_master #(
        .AXI_ADDR_WIDTH(AW),
        .AXI_DATA_WIDTH(DW),
        .AXI_BASE_ADDR (32'h0000_0000),
        .AXI_BASE_MASK (32'hFFFF_F000)
    ) dut (
        .axi_aclk   (clk),
        .axi_aresetn(rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_write  (cmd_write),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .cmd_wstrb  (cmd_wstrb),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_resp   (rsp_resp),
        .busy       (busy),
        .m_axi      (m_axi)
    );

    int n_chk = 0;
    int n_err = 0;

    // Current transaction, set by do_cmd and read by the slave/response processes.
    bit            c_wr, c_win;
    logic [AW-1:0] c_addr;
    logic [DW-1:0] c_wdata, c_rdata;
    logic [SW-1:0] c_wstrb;
    int            c_awd, c_wd, c_bd, c_ard, c_rd, c_hold, c_n;
    axi_resp_t     c_bresp, c_rresp;
    axi_resp_t     e_resp;
    logic [DW-1:0] e_rdata;
    bit            aw_hs, w_hs, ar_hs;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag);
        n_chk++;
        n_err++;
        $error("FAIL %s: observed=timeout expected=handshake within %0d cycles", tag, TMO);
    endtask

    // Reference behaviour: window is the first 4 KiB; writes return bresp with
    // zero data, reads return the slave's data/resp, anything else is DECERR.
    task automatic model(input bit wr, input logic [AW-1:0] addr, input axi_resp_t bresp,
                         input axi_resp_t rresp, input logic [DW-1:0] rdata,
                         output bit win, output axi_resp_t resp, output logic [DW-1:0] data);
        win = (addr < 32'h0000_1000);
        if (!win) begin
            resp = AXI_RESP_DECERR;
            data = '0;
        end else if (wr) begin
            resp = bresp;
            data = '0;
        end else begin
            resp = rresp;
            data = rdata;
        end
    endtask

    task automatic slave_aw();
        int t = 0;
        while (m_axi.awvalid !== 1'b1 && t < TMO) begin @(negedge clk); t++; end
        if (t >= TMO) begin timeout("aw_wait"); aw_hs = 1; return; end
        repeat (c_awd) begin
            chk("awvalid_held", m_axi.awvalid, 1'b1);
            chk("awaddr_stable", m_axi.awaddr, c_addr);
            @(negedge clk);
        end
        chk("awaddr", m_axi.awaddr, c_addr);
        chk("awprot", m_axi.awprot, 3'b000);
        m_axi.awready = 1'b1;
        @(posedge clk);
        aw_hs = 1;
        @(negedge clk);
        m_axi.awready = 1'b0;
        chk("awvalid_drop", m_axi.awvalid, 1'b0);
    endtask

    task automatic slave_w();
        int t = 0;
        while (m_axi.wvalid !== 1'b1 && t < TMO) begin @(negedge clk); t++; end
        if (t >= TMO) begin timeout("w_wait"); w_hs = 1; return; end
        repeat (c_wd) begin
            chk("wvalid_held", m_axi.wvalid, 1'b1);
            chk("wdata_stable", m_axi.wdata, c_wdata);
            chk("wstrb_stable", m_axi.wstrb, c_wstrb);
            @(negedge clk);
        end
        chk("wdata", m_axi.wdata, c_wdata);
        chk("wstrb", m_axi.wstrb, c_wstrb);
        m_axi.wready = 1'b1;
        @(posedge clk);
        w_hs = 1;
        @(negedge clk);
        m_axi.wready = 1'b0;
        chk("wvalid_drop", m_axi.wvalid, 1'b0);
    endtask

    task automatic slave_b();
        int t = 0;
        while (!(aw_hs && w_hs) && t < TMO) begin
            chk("bready_early", m_axi.bready, 1'b0);
            @(negedge clk);
            t++;
        end
        if (t >= TMO) begin timeout("b_wait_req"); return; end
        repeat (c_bd) @(negedge clk);
        m_axi.bvalid = 1'b1;
        m_axi.bresp  = c_bresp;
        t = 0;
        while (m_axi.bready !== 1'b1 && t < TMO) begin @(negedge clk); t++; end
        if (t >= TMO) begin timeout("bready_wait"); m_axi.bvalid = 1'b0; return; end
        @(posedge clk);
        @(negedge clk);
        m_axi.bvalid = 1'b0;
        m_axi.bresp  = AXI_RESP_OKAY;
        chk("bready_drop", m_axi.bready, 1'b0);
    endtask

    task automatic slave_ar();
        int t = 0;
        while (m_axi.arvalid !== 1'b1 && t < TMO) begin @(negedge clk); t++; end
        if (t >= TMO) begin timeout("ar_wait"); ar_hs = 1; return; end
        repeat (c_ard) begin
            chk("arvalid_held", m_axi.arvalid, 1'b1);
            chk("araddr_stable", m_axi.araddr, c_addr);
            @(negedge clk);
        end
        chk("araddr", m_axi.araddr, c_addr);
        chk("arprot", m_axi.arprot, 3'b000);
        m_axi.arready = 1'b1;
        @(posedge clk);
        ar_hs = 1;
        @(negedge clk);
        m_axi.arready = 1'b0;
        chk("arvalid_drop", m_axi.arvalid, 1'b0);
    endtask

    task automatic slave_r();
        int t = 0;
        while (!ar_hs && t < TMO) begin
            chk("rready_early", m_axi.rready, 1'b0);
            @(negedge clk);
            t++;
        end
        if (t >= TMO) begin timeout("r_wait_req"); return; end
        repeat (c_rd) @(negedge clk);
        m_axi.rvalid = 1'b1;
        m_axi.rdata  = c_rdata;
        m_axi.rresp  = c_rresp;
        t = 0;
        while (m_axi.rready !== 1'b1 && t < TMO) begin @(negedge clk); t++; end
        if (t >= TMO) begin timeout("rready_wait"); m_axi.rvalid = 1'b0; return; end
        @(posedge clk);
        @(negedge clk);
        m_axi.rvalid = 1'b0;
        m_axi.rdata  = '0;
        m_axi.rresp  = AXI_RESP_OKAY;
        chk("rready_drop", m_axi.rready, 1'b0);
    endtask

    task automatic rsp_proc();
        int t = 0;
        bit saw_wr = 0;
        bit saw_rd = 0;
        bit fast;
        while (rsp_valid !== 1'b1 && t < TMO) begin
            if (m_axi.awvalid === 1'b1 || m_axi.wvalid === 1'b1) saw_wr = 1;
            if (m_axi.arvalid === 1'b1) saw_rd = 1;
            chk("cmd_ready_low", cmd_ready, 1'b0);
            chk("busy_high", busy, 1'b1);
            @(negedge clk);
            t++;
        end
        if (t >= TMO) begin timeout("rsp_valid_wait"); return; end
        fast = !c_win || (c_awd == 0 && c_wd == 0 && c_bd == 0 && c_ard == 0 && c_rd == 0);
        if (fast) chk("rsp_latency", cyc - c_n, c_win ? 2 : 0);
        chk("aw_w_activity", saw_wr, c_win && c_wr);
        chk("ar_activity", saw_rd, c_win && !c_wr);
        chk("rsp_resp", rsp_resp, e_resp);
        chk("rsp_rdata", rsp_rdata, e_rdata);
        repeat (c_hold) begin
            @(negedge clk);
            chk("rsp_valid_hold", rsp_valid, 1'b1);
            chk("rsp_resp_hold", rsp_resp, e_resp);
            chk("rsp_rdata_hold", rsp_rdata, e_rdata);
            chk("cmd_ready_hold", cmd_ready, 1'b0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("rsp_valid_drop", rsp_valid, 1'b0);
        chk("cmd_ready_after", cmd_ready, 1'b1);
        chk("busy_after", busy, 1'b0);
    endtask

    task automatic do_cmd(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                          input logic [SW-1:0] wstrb, input int awd, input int wd, input int bd,
                          input int ard, input int rd, input axi_resp_t bresp, input axi_resp_t rresp,
                          input logic [DW-1:0] rdata, input int hold);
        int t = 0;
        c_wr = wr; c_addr = addr; c_wdata = wdata; c_wstrb = wstrb;
        c_awd = awd; c_wd = wd; c_bd = bd; c_ard = ard; c_rd = rd;
        c_bresp = bresp; c_rresp = rresp; c_rdata = rdata; c_hold = hold;
        model(wr, addr, bresp, rresp, rdata, c_win, e_resp, e_rdata);
        aw_hs = 0; w_hs = 0; ar_hs = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        cmd_wstrb = wstrb;
        while (cmd_ready !== 1'b1 && t < TMO) begin @(negedge clk); t++; end
        if (t >= TMO) begin timeout("cmd_accept"); cmd_valid = 1'b0; return; end
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_wdata = $urandom;
        c_n = cyc;
        fork
            begin if (c_win && c_wr)  slave_aw(); end
            begin if (c_win && c_wr)  slave_w();  end
            begin if (c_win && c_wr)  slave_b();  end
            begin if (c_win && !c_wr) slave_ar(); end
            begin if (c_win && !c_wr) slave_r();  end
            rsp_proc();
        join
    endtask

    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_data;
    int            t0;

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
        rsp_ready = 1'b0;
        m_axi.awready = 1'b0; m_axi.wready = 1'b0;
        m_axi.bvalid  = 1'b0; m_axi.bresp  = AXI_RESP_OKAY;
        m_axi.arready = 1'b0;
        m_axi.rvalid  = 1'b0; m_axi.rdata  = '0; m_axi.rresp = AXI_RESP_OKAY;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk("rst_rsp_resp", rsp_resp, 2'b00);
        chk("rst_awvalid", m_axi.awvalid, 1'b0);
        chk("rst_wvalid", m_axi.wvalid, 1'b0);
        chk("rst_arvalid", m_axi.arvalid, 1'b0);
        chk("rst_bready", m_axi.bready, 1'b0);
        chk("rst_rready", m_axi.rready, 1'b0);
        chk("rst_awaddr", m_axi.awaddr, 32'h0);
        chk("rst_wdata", m_axi.wdata, 32'h0);
        chk("rst_wstrb", m_axi.wstrb, 4'h0);
        chk("rst_araddr", m_axi.araddr, 32'h0);
        rst_n = 1'b1;
        #1 chk("cmd_ready_before_edge", cmd_ready, 1'b0);
        @(negedge clk);
        chk("cmd_ready_first_edge", cmd_ready, 1'b1);

        // Best-case write
        do_cmd(1'b1, 32'h0000_0004, 32'h0000_00A5, 4'b0001, 0, 0, 0, 0, 0,
               AXI_RESP_OKAY, AXI_RESP_OKAY, 32'h0, 0);
        // W accepted three cycles after AW
        do_cmd(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'b1111, 0, 3, 1, 0, 0,
               AXI_RESP_OKAY, AXI_RESP_OKAY, 32'h0, 0);
        // AW accepted after W
        do_cmd(1'b1, 32'h0000_0FFC, 32'h0BAD_F00D, 4'b0110, 2, 0, 0, 0, 0,
               AXI_RESP_SLVERR, AXI_RESP_OKAY, 32'h0, 1);
        // Read with slow R returning SLVERR
        do_cmd(1'b0, 32'h0000_0008, 32'h0, 4'b0000, 0, 0, 0, 0, 4,
               AXI_RESP_OKAY, AXI_RESP_SLVERR, 32'h1234_5678, 0);
        // Best-case read
        do_cmd(1'b0, 32'h0000_0020, 32'h0, 4'b0000, 0, 0, 0, 0, 0,
               AXI_RESP_OKAY, AXI_RESP_EXOKAY, 32'hCAFE_0001, 0);
        // Out-of-window read and write
        do_cmd(1'b0, 32'h0000_2000, 32'h0, 4'b0000, 0, 0, 0, 0, 0,
               AXI_RESP_OKAY, AXI_RESP_OKAY, 32'hFFFF_FFFF, 0);
        do_cmd(1'b1, 32'h0000_1000, 32'h5555_AAAA, 4'b1111, 0, 0, 0, 0, 0,
               AXI_RESP_OKAY, AXI_RESP_OKAY, 32'h0, 0);
        // Response back-pressure for 10 cycles
        do_cmd(1'b1, 32'h0000_0040, 32'h0000_1111, 4'b0011, 1, 1, 2, 0, 0,
               AXI_RESP_EXOKAY, AXI_RESP_OKAY, 32'h0, 10);

        // Asynchronous reset while AW/W are pending
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h0000_0100;
        cmd_wdata = 32'h7777_7777; cmd_wstrb = 4'hF;
        t0 = 0;
        while (cmd_ready !== 1'b1 && t0 < TMO) begin @(negedge clk); t0++; end
        if (t0 >= TMO) timeout("rst_cmd_accept");
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("pre_rst_awvalid", m_axi.awvalid, 1'b1);
        chk("pre_rst_wvalid", m_axi.wvalid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_awvalid", m_axi.awvalid, 1'b0);
        chk("async_rst_wvalid", m_axi.wvalid, 1'b0);
        chk("async_rst_busy", busy, 1'b0);
        chk("async_rst_cmd_ready", cmd_ready, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_cmd_ready", cmd_ready, 1'b1);
        do_cmd(1'b0, 32'h0000_0104, 32'h0, 4'b0000, 0, 0, 0, 0, 0,
               AXI_RESP_OKAY, AXI_RESP_OKAY, 32'hA5A5_5A5A, 0);

        // Randomized commands
        for (int i = 0; i < 40; i++) begin
            r_addr = ($urandom_range(0, 3) == 0) ? 32'($urandom) : (32'($urandom) & 32'h0000_0FFC);
            r_data = $urandom;
            do_cmd(1'($urandom_range(0, 1)), r_addr, r_data, 4'($urandom_range(0, 15)),
                   $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 3), $urandom_range(0, 3),
                   2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 32'($urandom),
                   $urandom_range(0, 2));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
